priority_decoder_pipe: RTL

//  Decoder partner of the 4x2 priority encoder: takes the encoder's code plus
//  its valid bit and rebuilds a one-hot vector (2-bit code -> 4 lines).

---
 rtl/priority_decoder_pkg.sv | 9 +
 rtl/priority_decoder_pipe_skid.sv | 61 ++++++
 rtl/priority_decoder_pipe.sv | 46 ++++
 3 files changed

// File: rtl/priority_decoder_pkg.sv
// priority_decoder_pkg: shared types and decode helper for the priority decoder pipe
package priority_decoder_pkg;
  localparam int DEF_IN_W = 2;
  localparam int DEF_OUT_W = 1 << DEF_IN_W;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
  function automatic logic [DEF_OUT_W-1:0] onehot_f(input logic [DEF_IN_W-1:0] code, input logic en);
    onehot_f = {{(DEF_OUT_W-1){1'b0}}, en} << code;
  endfunction
endpackage

// File: rtl/priority_decoder_pipe_skid.sv
// dec_skid_buf: two-entry registered skid buffer carrying the decoded payload
module dec_skid_buf
  import priority_decoder_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  state_t state, state_n;
  logic [W-1:0] or_q, sk_q;
  logic acc, pop, ld_or, ld_sk, from_sk;
  assign in_ready = !rst && state != FULL;
  assign out_valid = !rst && state != EMPTY;
  assign out_data = or_q;
  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_comb begin
    state_n = state;
    ld_or = 1'b0;
    ld_sk = 1'b0;
    from_sk = 1'b0;
    case (state)
      EMPTY: if (acc) begin
        ld_or = 1'b1;
        state_n = BUSY;
      end
      BUSY: if (acc && !pop) begin
        ld_sk = 1'b1;
        state_n = FULL;
      end else if (acc) begin
        ld_or = 1'b1;
      end else if (pop) begin
        state_n = EMPTY;
      end
      FULL: if (pop) begin
        ld_or = 1'b1;
        from_sk = 1'b1;
        state_n = BUSY;
      end
      default: state_n = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      or_q <= '0;
      sk_q <= '0;
    end else begin
      state <= state_n;
      if (ld_or) or_q <= from_sk ? sk_q : in_data;
      if (ld_sk) sk_q <= in_data;
    end
  end
endmodule

// File: rtl/priority_decoder_pipe.sv
// priority_decoder_pipe: registered 2->4 one-hot decoder with skid buffer and per-line hit counters
module priority_decoder_pipe
  import priority_decoder_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int OUT_W = 1 << IN_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_onehot,
  output logic [IN_W-1:0]  out_code,
  input  logic [IN_W-1:0]  cnt_sel,
  output logic [CNT_W-1:0] cnt_val,
  input  logic             cnt_clr
);
  logic [OUT_W-1:0] onehot;
  logic [CNT_W-1:0] cnt [OUT_W];
  logic acc;
  assign onehot = onehot_f(in_code, in_en);
  assign acc = in_valid && in_ready;
  assign cnt_val = cnt[cnt_sel];
  dec_skid_buf #(.W(OUT_W + IN_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({onehot, in_code}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data ({out_onehot, out_code})
  );
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      for (int i = 0; i < OUT_W; i++) cnt[i] <= '0;
    end else if (acc && in_en && cnt[in_code] != {CNT_W{1'b1}}) begin
      cnt[in_code] <= cnt[in_code] + 1'b1;
    end
  end
endmodule
